// File: rtl/sram_arb_pkg.sv
// Shared definitions for the external SRAM sequencer/arbiter: FSM encoding,
// port indices and strobe polarity.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } arb_state_e;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // SRAM strobes are active low; this is the released level.
  localparam logic STROBE_OFF = 1'b1;

  typedef struct packed {
    logic        write;
    logic [15:0] wdata;
    logic [1:0]  be;
  } sram_cmd_t;

endpackage

// File: rtl/sram_rr_grant.sv
// Two-requester round-robin grant. On a tie the requester not granted last
// time wins; the last-grant flag resets to B so A wins the first tie.
module sram_rr_grant
  import sram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       reset_in,  // synchronous, active low
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_b;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = 2'b00;
      gnt[last_b ? PORT_A : PORT_B] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_in)
      last_b <= 1'b1;
    else if (en && (|req))
      last_b <= gnt[PORT_B];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin sequencer for the 256Kx16 async SRAM. All pin-side
// outputs are registered; the data-bus enable never overlaps an active OE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              io_mainClk,
  input  logic              io_resetn,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_write,
  input  logic [15:0]       a_wdata,
  input  logic [1:0]        a_be,
  output logic              a_rsp_valid,
  output logic [15:0]       a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_write,
  input  logic [15:0]       b_wdata,
  input  logic [1:0]        b_be,
  output logic              b_rsp_valid,
  output logic [15:0]       b_rdata,
  output logic [ADDR_W-1:0] io_sram_addr,
  input  logic [15:0]       io_sram_dat_read,
  output logic [15:0]       io_sram_dat_write,
  output logic              io_sram_dat_writeEnable,
  output logic              io_sram_cs,
  output logic              io_sram_oe,
  output logic              io_sram_we,
  output logic              io_sram_lb,
  output logic              io_sram_ub
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_e        state, state_nxt;
  logic [1:0]        gnt;
  logic              idle, take, owner_b, is_wr;
  logic [3:0]        wait_cnt;
  sram_cmd_t         cmd;
  logic [ADDR_W-1:0] cmd_addr;

  // Gating with reset keeps ready low while reset is held.
  assign idle    = (state == IDLE) && io_resetn;
  assign a_ready = idle && gnt[PORT_A];
  assign b_ready = idle && gnt[PORT_B];
  assign take    = a_ready || b_ready;

  sram_rr_grant u_grant (
    .CLK      (io_mainClk),
    .reset_in (io_resetn),
    .en       (idle),
    .req      ({b_valid, a_valid}),
    .gnt      (gnt)
  );

  always_comb begin
    cmd_addr  = a_addr;
    cmd.write = a_write;
    cmd.wdata = a_wdata;
    cmd.be    = a_be;
    if (gnt[PORT_B]) begin
      cmd_addr  = b_addr;
      cmd.write = b_write;
      cmd.wdata = b_wdata;
      cmd.be    = b_be;
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == '0) state_nxt = is_wr ? HOLD : IDLE;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      owner_b                 <= 1'b0;
      is_wr                   <= 1'b0;
      wait_cnt                <= '0;
      io_sram_addr            <= '0;
      io_sram_dat_write       <= '0;
      io_sram_dat_writeEnable <= 1'b0;
      io_sram_cs              <= STROBE_OFF;
      io_sram_oe              <= STROBE_OFF;
      io_sram_we              <= STROBE_OFF;
      io_sram_lb              <= STROBE_OFF;
      io_sram_ub              <= STROBE_OFF;
      a_rdata                 <= '0;
      b_rdata                 <= '0;
      a_rsp_valid             <= 1'b0;
      b_rsp_valid             <= 1'b0;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      case (state)
        IDLE: if (take) begin
          owner_b                 <= gnt[PORT_B];
          is_wr                   <= cmd.write;
          io_sram_addr            <= cmd_addr;
          io_sram_cs              <= ~STROBE_OFF;
          io_sram_lb              <= ~cmd.be[0];
          io_sram_ub              <= ~cmd.be[1];
          // A read drops OE now; a write drives the bus with OE released.
          io_sram_oe              <= cmd.write ? STROBE_OFF : ~STROBE_OFF;
          io_sram_we              <= STROBE_OFF;
          io_sram_dat_writeEnable <= cmd.write;
          if (cmd.write) io_sram_dat_write <= cmd.wdata;
        end
        SETUP: begin
          wait_cnt <= WAIT_LOAD;
          if (is_wr) io_sram_we <= ~STROBE_OFF;
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            a_rsp_valid <= !owner_b;
            b_rsp_valid <= owner_b;
            if (is_wr) begin
              io_sram_we <= STROBE_OFF;
            end else begin
              io_sram_cs <= STROBE_OFF;
              io_sram_oe <= STROBE_OFF;
              io_sram_lb <= STROBE_OFF;
              io_sram_ub <= STROBE_OFF;
              if (owner_b) b_rdata <= io_sram_dat_read;
              else         a_rdata <= io_sram_dat_read;
            end
          end
        end
        HOLD: begin
          io_sram_cs              <= STROBE_OFF;
          io_sram_lb              <= STROBE_OFF;
          io_sram_ub              <= STROBE_OFF;
          io_sram_dat_writeEnable <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (W=2, 1, 15), a pad-level SRAM model
// and a transaction-timing reference model compared every cycle.
module tb_sram_arbiter;

  localparam int NI = 3;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic io_resetn = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid [NI], b_valid [NI], a_ready [NI], b_ready [NI];
  logic          a_write [NI], b_write [NI], a_rsp_valid [NI], b_rsp_valid [NI];
  logic [AW-1:0] a_addr [NI], b_addr [NI], sram_addr [NI];
  logic [15:0]   a_wdata [NI], b_wdata [NI], a_rdata [NI], b_rdata [NI];
  logic [15:0]   dat_rd [NI], dat_wr [NI];
  logic [1:0]    a_be [NI], b_be [NI];
  logic          de [NI], cs [NI], oe [NI], we [NI], lb [NI], ub [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .io_mainClk(clk), .io_resetn(io_resetn),
      .a_valid(a_valid[g]), .a_ready(a_ready[g]), .a_addr(a_addr[g]), .a_write(a_write[g]),
      .a_wdata(a_wdata[g]), .a_be(a_be[g]), .a_rsp_valid(a_rsp_valid[g]), .a_rdata(a_rdata[g]),
      .b_valid(b_valid[g]), .b_ready(b_ready[g]), .b_addr(b_addr[g]), .b_write(b_write[g]),
      .b_wdata(b_wdata[g]), .b_be(b_be[g]), .b_rsp_valid(b_rsp_valid[g]), .b_rdata(b_rdata[g]),
      .io_sram_addr(sram_addr[g]), .io_sram_dat_read(dat_rd[g]), .io_sram_dat_write(dat_wr[g]),
      .io_sram_dat_writeEnable(de[g]), .io_sram_cs(cs[g]), .io_sram_oe(oe[g]),
      .io_sram_we(we[g]), .io_sram_lb(lb[g]), .io_sram_ub(ub[g])
    );
  end

  function automatic int wv(input int i);
    return i == 0 ? 2 : (i == 1 ? 1 : 15);
  endfunction

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit rst_edge = 1'b0, started = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  // Memories: smem is what the pins actually did, rmem is what the commands imply.
  logic [15:0] smem [logic [19:0]];
  logic [15:0] rmem [logic [19:0]];

  function automatic logic [19:0] key(input int i, input logic [AW-1:0] a);
    logic [1:0] ii;
    ii = 2'(i);
    return {ii, a};
  endfunction
  function automatic logic [15:0] dflt(input logic [19:0] k);
    return k[15:0] ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] smem_rd(input logic [19:0] k);
    return smem.exists(k) ? smem[k] : dflt(k);
  endfunction
  function automatic logic [15:0] rmem_rd(input logic [19:0] k);
    return rmem.exists(k) ? rmem[k] : dflt(k);
  endfunction

  // Asynchronous SRAM pad model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [15:0] w;
      dat_rd[i] = (!cs[i] && !oe[i]) ? smem_rd(key(i, sram_addr[i])) : 16'hDEAD;
      if (!cs[i] && !we[i]) begin
        w = smem_rd(key(i, sram_addr[i]));
        if (!lb[i]) w[7:0]  = dat_wr[i][7:0];
        if (!ub[i]) w[15:8] = dat_wr[i][15:8];
        smem[key(i, sram_addr[i])] = w;
      end
    end
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !io_resetn;
    if (!io_resetn) started <= 1'b1;
  end

  // Reference model: one outstanding transaction per instance, timed from its grant cycle.
  bit            m_busy [NI], m_port [NI], m_wr [NI], m_lastb [NI];
  int            m_t [NI];
  logic [AW-1:0] m_addr [NI];
  logic [15:0]   m_wd [NI];
  logic [1:0]    m_be [NI];
  logic [15:0]   exp_rd [NI][2];
  logic [31:0]   ghist [NI];

  task automatic step(input int i);
    int w, d;
    bit e_cs, e_oe, e_we, e_lb, e_ub, e_de, e_ra, e_rb, ga, gb;
    logic [15:0] nv, wd;
    w = wv(i);
    e_cs = 1; e_oe = 1; e_we = 1; e_lb = 1; e_ub = 1; e_de = 0; e_ra = 0; e_rb = 0;
    if (rst_edge) begin
      m_busy[i] = 0; m_lastb[i] = 1; exp_rd[i][0] = '0; exp_rd[i][1] = '0;
    end
    if (m_busy[i]) begin
      d = cyc - m_t[i];
      if (m_wr[i]) begin
        e_cs = !(d >= 1 && d <= w + 2);
        e_we = !(d >= 2 && d <= w + 1);
        e_de = (d >= 1 && d <= w + 2);
      end else begin
        e_cs = !(d >= 1 && d <= w + 1);
        e_oe = e_cs;
      end
      e_lb = e_cs || !m_be[i][0];
      e_ub = e_cs || !m_be[i][1];
      if (d == w + 2) begin
        if (m_port[i]) e_rb = 1; else e_ra = 1;
        if (m_wr[i]) begin
          nv = rmem_rd(key(i, m_addr[i]));
          wd = m_wd[i];
          if (m_be[i][0]) nv[7:0]  = wd[7:0];
          if (m_be[i][1]) nv[15:8] = wd[15:8];
          rmem[key(i, m_addr[i])] = nv;
        end else begin
          exp_rd[i][m_port[i]] = rmem_rd(key(i, m_addr[i]));
        end
      end
      if (!e_cs) chk("addr", i, 32'(sram_addr[i]), 32'(m_addr[i]));
      if (e_de)  chk("dat_write", i, 32'(dat_wr[i]), 32'(m_wd[i]));
      if (d >= (m_wr[i] ? w + 3 : w + 2)) m_busy[i] = 0;
    end
    chk("cs", i, 32'(cs[i]), 32'(e_cs));
    chk("oe", i, 32'(oe[i]), 32'(e_oe));
    chk("we", i, 32'(we[i]), 32'(e_we));
    chk("lb", i, 32'(lb[i]), 32'(e_lb));
    chk("ub", i, 32'(ub[i]), 32'(e_ub));
    chk("dat_we", i, 32'(de[i]), 32'(e_de));
    chk("turnaround", i, 32'(!(!oe[i] && de[i])), 32'd1);
    chk("a_rsp_valid", i, 32'(a_rsp_valid[i]), 32'(e_ra));
    chk("b_rsp_valid", i, 32'(b_rsp_valid[i]), 32'(e_rb));
    chk("a_rdata", i, 32'(a_rdata[i]), 32'(exp_rd[i][0]));
    chk("b_rdata", i, 32'(b_rdata[i]), 32'(exp_rd[i][1]));
    ga = 0; gb = 0;
    if (io_resetn && !m_busy[i]) begin
      if (a_valid[i] && b_valid[i]) begin
        if (m_lastb[i]) ga = 1; else gb = 1;
      end else begin
        ga = a_valid[i]; gb = b_valid[i];
      end
    end
    chk("a_ready", i, 32'(a_ready[i]), 32'(ga));
    chk("b_ready", i, 32'(b_ready[i]), 32'(gb));
    if (ga || gb) begin
      m_busy[i] = 1; m_t[i] = cyc; m_port[i] = gb; m_lastb[i] = gb;
      m_wr[i]   = gb ? b_write[i] : a_write[i];
      m_addr[i] = gb ? b_addr[i]  : a_addr[i];
      m_wd[i]   = gb ? b_wdata[i] : a_wdata[i];
      m_be[i]   = gb ? b_be[i]    : a_be[i];
      ghist[i]  = {ghist[i][30:0], gb};
    end
  endtask

  always @(negedge clk)
    if (started)
      for (int i = 0; i < NI; i++) step(i);

  // Drivers: fields change #1 after a rising edge and are held until ready.
  task automatic do_cmd(input int i, input bit p, input bit wr, input logic [AW-1:0] ad,
                        input logic [15:0] wd, input logic [1:0] be, output int t);
    bit got;
    got = 0; t = -1;
    if (p) begin b_valid[i] = 1; b_write[i] = wr; b_addr[i] = ad; b_wdata[i] = wd; b_be[i] = be; end
    else   begin a_valid[i] = 1; a_write[i] = wr; a_addr[i] = ad; a_wdata[i] = wd; a_be[i] = be; end
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      got = p ? b_ready[i] : a_ready[i];
    end
    if (got) t = cyc; else chk("ready_timeout", i, 32'd0, 32'd1);
    @(posedge clk); #1;
    if (p) b_valid[i] = 0; else a_valid[i] = 0;
  endtask

  task automatic wait_rsp(input int i, input bit p, input int t, output int lat);
    bit got;
    got = 0; lat = -1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = p ? b_rsp_valid[i] : a_rsp_valid[i];
    end
    if (got) lat = cyc - t; else chk("rsp_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic stream(input int i, input bit p, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      do_cmd(i, p, 1'($urandom_range(0, 1)), 18'(18'h300 + $urandom_range(0, 7)),
             16'($urandom), 2'($urandom_range(0, 3)), t);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic chk_idle(input int i);
    chk("idle_cs", i, 32'(cs[i]), 32'd1);
    chk("idle_oe", i, 32'(oe[i]), 32'd1);
    chk("idle_we", i, 32'(we[i]), 32'd1);
    chk("idle_lb_ub", i, 32'({lb[i], ub[i]}), 32'd3);
    chk("idle_dat_we", i, 32'(de[i]), 32'd0);
    chk("idle_addr", i, 32'(sram_addr[i]), 32'd0);
    chk("idle_rdata", i, 32'({a_rdata[i], b_rdata[i]}), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, lat;
    logic [15:0] wd;
    for (int i = 0; i < NI; i++) begin
      a_valid[i] = 0; b_valid[i] = 0; a_write[i] = 0; b_write[i] = 0;
      a_addr[i] = '0; b_addr[i] = '0; a_wdata[i] = '0; b_wdata[i] = '0;
      a_be[i] = '0; b_be[i] = '0; dat_rd[i] = '0; ghist[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 io_resetn = 1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk_idle(i);

    for (int i = 0; i < NI; i++) begin
      @(posedge clk); #1;
      // Contention straight out of reset: A wins the first tie, then strict alternation.
      fork
        begin
          int ta;
          for (int k = 0; k < 4; k++) do_cmd(i, 0, 0, 18'(18'h100 + k), 16'h0, 2'b11, ta);
        end
        begin
          int tb2;
          for (int k = 0; k < 4; k++) do_cmd(i, 1, 0, 18'(18'h200 + k), 16'h0, 2'b11, tb2);
        end
      join
      repeat (40) @(posedge clk);
      #1 chk("grant_order", i, 32'(ghist[i][7:0]), 32'h55);

      smem[key(i, 18'h1234)] = 16'hBEEF;
      rmem[key(i, 18'h1234)] = 16'hBEEF;
      do_cmd(i, 0, 0, 18'h1234, 16'h0, 2'b11, t);
      wait_rsp(i, 0, t, lat);
      chk("rd_latency", i, 32'(lat), 32'(i == 0 ? 4 : wv(i) + 2));
      chk("rd_data", i, 32'(a_rdata[i]), 32'hBEEF);

      @(posedge clk); #1;
      smem[key(i, 18'h3FFFF)] = 16'h1234;
      rmem[key(i, 18'h3FFFF)] = 16'h1234;
      do_cmd(i, 1, 1, 18'h3FFFF, 16'h00A5, 2'b01, t);
      wait_rsp(i, 1, t, lat);
      chk("wr_latency", i, 32'(lat), 32'(i == 0 ? 4 : wv(i) + 2));
      repeat (2) @(negedge clk);
      chk("byte_write_mem", i, 32'(smem_rd(key(i, 18'h3FFFF))), 32'h12A5);

      @(posedge clk); #1;
      wd = 16'($urandom);
      do_cmd(i, 0, 1, 18'h55, wd, 2'b11, t);
      do_cmd(i, 0, 0, 18'h55, 16'h0, 2'b11, t);
      wait_rsp(i, 0, t, lat);
      chk("turnaround_data", i, 32'(a_rdata[i]), 32'(wd));

      @(posedge clk); #1;
      smem[key(i, 18'h77)] = 16'hCAFE;
      rmem[key(i, 18'h77)] = 16'hCAFE;
      do_cmd(i, 1, 1, 18'h77, 16'h1111, 2'b00, t);
      wait_rsp(i, 1, t, lat);
      chk("be00_latency", i, 32'(lat), 32'(wv(i) + 2));
      repeat (2) @(negedge clk);
      chk("be00_mem", i, 32'(smem_rd(key(i, 18'h77))), 32'hCAFE);

      // Reset landing while a write is in SETUP.
      @(posedge clk); #1;
      do_cmd(i, 0, 1, 18'h99, 16'h4242, 2'b11, t);
      io_resetn = 0;
      repeat (3) @(posedge clk);
      #1 io_resetn = 1;
      @(negedge clk);
      chk_idle(i);
      chk("abandoned_write_mem", i, 32'(smem_rd(key(i, 18'h99))), 32'(dflt(key(i, 18'h99))));

      @(posedge clk); #1;
      fork
        stream(i, 0, 30);
        stream(i, 1, 30);
      join
      repeat (40) @(posedge clk);
      #1;
    end

    foreach (rmem[k]) chk("mem_final", int'(k[19:18]), 32'(smem_rd(k)), 32'(rmem[k]));
    foreach (smem[k]) chk("mem_final", int'(k[19:18]), 32'(rmem_rd(k)), 32'(smem[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
